// File: rtl/pong_pkg.sv
// Shared types and defaults for the Pong game sequencer.
package pong_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_POINT = 3'd3,
        ST_OVER  = 3'd4
    } pong_state_t;

    localparam int unsigned WIN_SCORE_DEF    = 7;
    localparam int unsigned SERVE_FRAMES_DEF = 60;
    localparam int unsigned POINT_FRAMES_DEF = 90;
    localparam int unsigned OVER_FRAMES_DEF  = 300;

    // Frame counter width: enough to hold the largest (frames-1) load value, never zero.
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                              input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/frame_countdown.sv
// Counts new-frame strobes down from a loaded value; flags the strobe that arrives at zero.
module frame_countdown #(
    parameter int unsigned CNT_W = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             nf_i,
    output logic             done_c_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // A load wins over a same-cycle strobe, so the entry-cycle strobe is never counted.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (nf_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_c_o = nf_i && (cnt_q == '0);

endmodule

// File: rtl/pong_game_sequencer.sv
// Frame-driven Pong game controller: phase sequencing, scoring, physics enable and puck re-centre.
module pong_game_sequencer
    import pong_pkg::*;
#(
    parameter int unsigned WIN_SCORE    = WIN_SCORE_DEF,
    parameter int unsigned SERVE_FRAMES = SERVE_FRAMES_DEF,
    parameter int unsigned POINT_FRAMES = POINT_FRAMES_DEF,
    parameter int unsigned OVER_FRAMES  = OVER_FRAMES_DEF,
    localparam int unsigned SCORE_W     = $clog2(WIN_SCORE + 1)
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_nf,
    input  logic               i_start,
    input  logic               i_miss_l,
    input  logic               i_miss_r,
    output logic [2:0]         o_state,
    output logic               o_run,
    output logic               o_puck_reset,
    output logic               o_serve_dir,
    output logic [SCORE_W-1:0] o_score_l,
    output logic [SCORE_W-1:0] o_score_r,
    output logic               o_winner_valid,
    output logic               o_winner
);

    localparam int unsigned CNT_W = cnt_width(SERVE_FRAMES, POINT_FRAMES, OVER_FRAMES);

    localparam logic [CNT_W-1:0]   SERVE_LOAD = CNT_W'(SERVE_FRAMES - 1);
    localparam logic [CNT_W-1:0]   POINT_LOAD = CNT_W'(POINT_FRAMES - 1);
    localparam logic [CNT_W-1:0]   OVER_LOAD  = CNT_W'(OVER_FRAMES - 1);
    localparam logic [SCORE_W-1:0] WIN_VAL    = SCORE_W'(WIN_SCORE);

    pong_state_t        state_q, state_d;
    logic [SCORE_W-1:0] score_l_q, score_l_d;
    logic [SCORE_W-1:0] score_r_q, score_r_d;
    logic               serve_dir_q, serve_dir_d;
    logic               winner_q, winner_d;
    logic               puck_reset_q, puck_reset_d;
    logic               run_q, run_d;
    logic               winner_valid_q, winner_valid_d;
    logic               start_q;

    logic               start_edge;
    logic               cnt_load;
    logic [CNT_W-1:0]   cnt_load_val;
    logic               cnt_done;
    logic [SCORE_W-1:0] score_l_inc, score_r_inc;

    // start_q resets high so a button held through reset release is not a start.
    assign start_edge  = i_start & ~start_q;
    assign score_l_inc = (score_l_q >= WIN_VAL) ? score_l_q : score_l_q + SCORE_W'(1);
    assign score_r_inc = (score_r_q >= WIN_VAL) ? score_r_q : score_r_q + SCORE_W'(1);

    frame_countdown #(
        .CNT_W (CNT_W)
    ) u_frame_countdown (
        .clk_i      (i_clk),
        .rst_ni     (i_rst_n),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val),
        .nf_i       (i_nf),
        .done_c_o   (cnt_done)
    );

    always_comb begin
        state_d      = state_q;
        score_l_d    = score_l_q;
        score_r_d    = score_r_q;
        serve_dir_d  = serve_dir_q;
        winner_d     = winner_q;
        puck_reset_d = 1'b0;
        cnt_load     = 1'b0;
        cnt_load_val = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (start_edge) begin
                    score_l_d    = '0;
                    score_r_d    = '0;
                    serve_dir_d  = 1'b1;
                    puck_reset_d = 1'b1;
                    cnt_load     = 1'b1;
                    cnt_load_val = SERVE_LOAD;
                    state_d      = ST_SERVE;
                end
            end
            ST_SERVE: begin
                if (cnt_done) state_d = ST_PLAY;
            end
            ST_PLAY: begin
                if (i_miss_l && i_miss_r) begin
                    cnt_load     = 1'b1;
                    cnt_load_val = POINT_LOAD;
                    state_d      = ST_POINT;
                end else if (i_miss_l) begin
                    score_r_d   = score_r_inc;
                    serve_dir_d = 1'b0;
                    cnt_load    = 1'b1;
                    if (score_r_inc == WIN_VAL) begin
                        winner_d     = 1'b1;
                        cnt_load_val = OVER_LOAD;
                        state_d      = ST_OVER;
                    end else begin
                        cnt_load_val = POINT_LOAD;
                        state_d      = ST_POINT;
                    end
                end else if (i_miss_r) begin
                    score_l_d   = score_l_inc;
                    serve_dir_d = 1'b1;
                    cnt_load    = 1'b1;
                    if (score_l_inc == WIN_VAL) begin
                        winner_d     = 1'b0;
                        cnt_load_val = OVER_LOAD;
                        state_d      = ST_OVER;
                    end else begin
                        cnt_load_val = POINT_LOAD;
                        state_d      = ST_POINT;
                    end
                end
            end
            ST_POINT: begin
                if (cnt_done) begin
                    puck_reset_d = 1'b1;
                    cnt_load     = 1'b1;
                    cnt_load_val = SERVE_LOAD;
                    state_d      = ST_SERVE;
                end
            end
            ST_OVER: begin
                // A new game takes priority over the display timeout.
                if (start_edge) begin
                    score_l_d    = '0;
                    score_r_d    = '0;
                    serve_dir_d  = 1'b1;
                    puck_reset_d = 1'b1;
                    cnt_load     = 1'b1;
                    cnt_load_val = SERVE_LOAD;
                    state_d      = ST_SERVE;
                end else if (cnt_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        run_d          = (state_d == ST_PLAY);
        winner_valid_d = (state_d == ST_OVER);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q        <= ST_IDLE;
            score_l_q      <= '0;
            score_r_q      <= '0;
            serve_dir_q    <= 1'b1;
            winner_q       <= 1'b0;
            puck_reset_q   <= 1'b0;
            run_q          <= 1'b0;
            winner_valid_q <= 1'b0;
            start_q        <= 1'b1;
        end else begin
            state_q        <= state_d;
            score_l_q      <= score_l_d;
            score_r_q      <= score_r_d;
            serve_dir_q    <= serve_dir_d;
            winner_q       <= winner_d;
            puck_reset_q   <= puck_reset_d;
            run_q          <= run_d;
            winner_valid_q <= winner_valid_d;
            start_q        <= i_start;
        end
    end

    assign o_state        = state_q;
    assign o_run          = run_q;
    assign o_puck_reset   = puck_reset_q;
    assign o_serve_dir    = serve_dir_q;
    assign o_score_l      = score_l_q;
    assign o_score_r      = score_r_q;
    assign o_winner_valid = winner_valid_q;
    assign o_winner       = winner_q;

endmodule

// File: tb/tb_pong_game_sequencer.sv
// Bench for pong_game_sequencer: directed scenarios plus random play against a frames-remaining model.
module tb_pong_game_sequencer;

    localparam int unsigned WIN = 2;
    localparam int unsigned SF  = 3;
    localparam int unsigned PF  = 4;
    localparam int unsigned OF  = 5;
    localparam int unsigned SW  = $clog2(WIN + 1);
    localparam int unsigned VW  = 8 + 2 * SW;

    logic          clk = 1'b0;
    logic          rst_n, nf, start, ml, mr;
    logic [2:0]    st;
    logic          run, pr, dir, wv, win;
    logic [SW-1:0] sl, sr;
    logic [VW-1:0] dut_vec;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: phase code, strobes still needed to leave the phase, scores, serve direction, winner.
    int m_state, m_left, m_sl, m_sr;
    bit m_dir, m_win, m_pr, m_prev;

    always #5 clk = ~clk;

    pong_game_sequencer #(
        .WIN_SCORE    (WIN),
        .SERVE_FRAMES (SF),
        .POINT_FRAMES (PF),
        .OVER_FRAMES  (OF)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_nf           (nf),
        .i_start        (start),
        .i_miss_l       (ml),
        .i_miss_r       (mr),
        .o_state        (st),
        .o_run          (run),
        .o_puck_reset   (pr),
        .o_serve_dir    (dir),
        .o_score_l      (sl),
        .o_score_r      (sr),
        .o_winner_valid (wv),
        .o_winner       (win)
    );

    assign dut_vec = {st, run, pr, dir, sl, sr, wv, win};

    function automatic logic [VW-1:0] model_vec();
        return {3'(m_state), (m_state == 2), m_pr, m_dir, SW'(m_sl), SW'(m_sr),
                (m_state == 4), m_win};
    endfunction

    function automatic logic [VW-1:0] reset_vec();
        return {3'd0, 1'b0, 1'b0, 1'b1, SW'(0), SW'(0), 1'b0, 1'b0};
    endfunction

    function automatic void model_reset();
        m_state = 0; m_left = 0; m_sl = 0; m_sr = 0;
        m_dir = 1'b1; m_win = 1'b0; m_pr = 1'b0; m_prev = 1'b1;
    endfunction

    function automatic void model_new_game();
        m_sl = 0; m_sr = 0; m_dir = 1'b1; m_pr = 1'b1;
        m_state = 1; m_left = SF;
    endfunction

    function automatic void model_score(input bit right_scored);
        if (right_scored) begin
            m_sr  = (m_sr + 1 > WIN) ? WIN : m_sr + 1;
            m_dir = 1'b0;
        end else begin
            m_sl  = (m_sl + 1 > WIN) ? WIN : m_sl + 1;
            m_dir = 1'b1;
        end
        if ((right_scored ? m_sr : m_sl) == WIN) begin
            m_win = right_scored; m_state = 4; m_left = OF;
        end else begin
            m_state = 3; m_left = PF;
        end
    endfunction

    function automatic void model_step(input bit f, input bit s, input bit l, input bit r);
        bit edge_s;
        edge_s = s && !m_prev;
        m_prev = s;
        m_pr   = 1'b0;
        case (m_state)
            0: if (edge_s) model_new_game();
            1: if (f) begin
                   m_left--;
                   if (m_left == 0) m_state = 2;
               end
            2: if (l && r) begin
                   m_state = 3; m_left = PF;
               end else if (l) model_score(1'b1);
               else if (r) model_score(1'b0);
            3: if (f) begin
                   m_left--;
                   if (m_left == 0) begin
                       m_pr = 1'b1; m_state = 1; m_left = SF;
                   end
               end
            4: if (edge_s) model_new_game();
               else if (f) begin
                   m_left--;
                   if (m_left == 0) m_state = 0;
               end
            default: ;
        endcase
    endfunction

    task automatic step(input bit f, input bit s, input bit l, input bit r);
        @(negedge clk);
        nf = f; start = s; ml = l; mr = r;
        @(posedge clk);
        model_step(f, s, l, r);
        #1;
    endtask

    // Start a game from IDLE (start already low) and run the serve out, comparing every cycle.
    task automatic to_play(input string tag);
        step(0, 1, 0, 0);
        n_tests++;
        if (dut_vec !== model_vec()) begin
            n_fail++; $display("FAIL %s_start: got %h expected %h", tag, dut_vec, model_vec());
        end
        step(0, 0, 0, 0);
        for (int i = 0; i < int'(SF); i++) begin
            step(1, 0, 0, 0);
            n_tests++;
            if (dut_vec !== model_vec()) begin
                n_fail++; $display("FAIL %s_serve: got %h expected %h", tag, dut_vec, model_vec());
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b1; nf = 1'b0; ml = 1'b0; mr = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (dut_vec !== reset_vec()) begin
            n_fail++; $display("FAIL reset_values: got %h expected %h", dut_vec, reset_vec());
        end
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1, 1, 0, 0);
            n_tests++;
            if (st !== 3'd0 || pr !== 1'b0 || sl !== '0 || sr !== '0) begin
                n_fail++; $display("FAIL reset_held_start: state %0d puck_reset %0b scores %0d/%0d expected 0 0 0/0",
                                   st, pr, sl, sr);
            end
        end
        step(0, 0, 0, 0);
    endtask

    task automatic test_serve();
        step(1, 1, 0, 0);
        n_tests++;
        if (st !== 3'd1 || pr !== 1'b1 || dir !== 1'b1) begin
            n_fail++; $display("FAIL serve_entry: state %0d puck_reset %0b dir %0b expected 1 1 1", st, pr, dir);
        end
        for (int i = 0; i < int'(SF); i++) begin
            step(0, 1, 0, 0);
            step(0, 0, 0, 0);
            n_tests++;
            if (st !== 3'd1 || pr !== 1'b0 || run !== 1'b0) begin
                n_fail++; $display("FAIL serve_hold: state %0d puck_reset %0b run %0b expected 1 0 0", st, pr, run);
            end
            step(1, 0, 1, 1);
            n_tests++;
            if (dut_vec !== model_vec()) begin
                n_fail++; $display("FAIL serve_count: got %h expected %h", dut_vec, model_vec());
            end
        end
        n_tests++;
        if (st !== 3'd2 || run !== 1'b1) begin
            n_fail++; $display("FAIL serve_to_play: state %0d run %0b expected 2 1", st, run);
        end
    endtask

    task automatic test_miss_r();
        step(1, 0, 0, 1);
        n_tests++;
        if (sl !== SW'(1) || dir !== 1'b1 || st !== 3'd3 || run !== 1'b0) begin
            n_fail++; $display("FAIL miss_r: score_l %0d dir %0b state %0d run %0b expected 1 1 3 0",
                               sl, dir, st, run);
        end
        for (int i = 0; i < int'(PF); i++) begin
            step(1, 0, i[0], 0);
            n_tests++;
            if (dut_vec !== model_vec()) begin
                n_fail++; $display("FAIL point_count: got %h expected %h", dut_vec, model_vec());
            end
        end
        n_tests++;
        if (pr !== 1'b1 || st !== 3'd1) begin
            n_fail++; $display("FAIL point_expiry: puck_reset %0b state %0d expected 1 1", pr, st);
        end
        for (int i = 0; i < int'(SF); i++) step(1, 0, 0, 0);
    endtask

    task automatic test_both_miss();
        step(0, 0, 1, 1);
        n_tests++;
        if (st !== 3'd3 || sl !== SW'(1) || sr !== '0 || dir !== 1'b1) begin
            n_fail++; $display("FAIL both_miss: state %0d scores %0d/%0d dir %0b expected 3 1/0 1",
                               st, sl, sr, dir);
        end
        for (int i = 0; i < int'(PF + SF); i++) step(1, 0, 0, 0);
        n_tests++;
        if (st !== 3'd2) begin
            n_fail++; $display("FAIL both_miss_return: state %0d expected 2", st);
        end
    endtask

    task automatic test_back_to_back_and_win();
        step(0, 0, 1, 0);
        step(0, 0, 0, 1);
        n_tests++;
        if (sr !== SW'(1) || sl !== SW'(1) || dir !== 1'b0 || st !== 3'd3) begin
            n_fail++; $display("FAIL back_to_back: scores %0d/%0d dir %0b state %0d expected 1/1 0 3",
                               sl, sr, dir, st);
        end
        for (int i = 0; i < int'(PF + SF); i++) step(1, 0, 0, 0);
        step(0, 0, 1, 0);
        n_tests++;
        if (sr !== SW'(2) || st !== 3'd4 || wv !== 1'b1 || win !== 1'b1 || run !== 1'b0) begin
            n_fail++; $display("FAIL win_right: score_r %0d state %0d valid %0b winner %0b run %0b expected 2 4 1 1 0",
                               sr, st, wv, win, run);
        end
        for (int i = 0; i < int'(OF); i++) begin
            step(1, 0, 1, 1);
            n_tests++;
            if (dut_vec !== model_vec()) begin
                n_fail++; $display("FAIL over_count: got %h expected %h", dut_vec, model_vec());
            end
        end
        n_tests++;
        if (st !== 3'd0 || sr !== SW'(2) || sl !== SW'(1) || wv !== 1'b0) begin
            n_fail++; $display("FAIL over_to_idle: state %0d scores %0d/%0d valid %0b expected 0 1/2 0",
                               st, sl, sr, wv);
        end
    endtask

    task automatic test_over_restart();
        to_play("restart");
        step(0, 0, 1, 0);
        for (int i = 0; i < int'(PF + SF); i++) step(1, 0, 0, 0);
        step(0, 0, 1, 0);
        for (int i = 0; i < int'(OF) - 1; i++) step(1, 0, 0, 0);
        n_tests++;
        if (st !== 3'd4) begin
            n_fail++; $display("FAIL restart_in_over: state %0d expected 4", st);
        end
        step(1, 1, 0, 0);
        n_tests++;
        if (st !== 3'd1 || sl !== '0 || sr !== '0 || pr !== 1'b1 || wv !== 1'b0) begin
            n_fail++; $display("FAIL over_restart: state %0d scores %0d/%0d puck_reset %0b valid %0b expected 1 0/0 1 0",
                               st, sl, sr, pr, wv);
        end
        step(0, 0, 0, 0);
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < int'(SF); i++) step(1, 0, 0, 0);
        step(0, 0, 0, 1);
        for (int i = 0; i < int'(PF + SF); i++) step(1, 0, 0, 0);
        n_tests++;
        if (st !== 3'd2 || sl !== SW'(1)) begin
            n_fail++; $display("FAIL async_setup: state %0d score_l %0d expected 2 1", st, sl);
        end
        #1 rst_n = 1'b0;
        #1;
        n_tests++;
        if (dut_vec !== reset_vec()) begin
            n_fail++; $display("FAIL async_reset: got %h expected %h", dut_vec, reset_vec());
        end
        model_reset();
        @(negedge clk);
        nf = 1'b0; start = 1'b0; ml = 1'b0; mr = 1'b0;
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic test_random();
        bit s;
        s = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) s = ~s;
            step(($urandom_range(0, 2) == 0), s, ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 7) == 0));
            n_tests++;
            if (dut_vec !== model_vec()) begin
                n_fail++; $display("FAIL random_cycle %0d: got %h expected %h", i, dut_vec, model_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_serve();
        test_miss_r();
        test_both_miss();
        test_back_to_back_and_win();
        test_over_restart();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pong_game_sequencer.md
# pong_game_sequencer

Frame-driven game controller for the 720p Pong datapath. Sequences the game through attract, serve, play, point and game-over phases. Gates the puck/paddle physics update enable and issues puck re-centre pulses. Keeps both players' scores and decides the winner. Sits between the video signal generator's new-frame strobe and the Pong renderer/physics, in the pixel clock domain.

## Interface
- WIN_SCORE, 7: points needed to win; scores saturate here.
- SERVE_FRAMES, 60: frames held in SERVE before play starts (≥1).
- POINT_FRAMES, 90: frames held in POINT after a miss (≥1).
- OVER_FRAMES, 300: frames held in OVER before returning to IDLE (≥1).
- i_clk  in  1  pixel clock.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_nf  in  1  new-frame strobe, one cycle high per frame.
- i_start  in  1  start button level, already synchronised and debounced.
- i_miss_l  in  1  puck passed the left edge (right player scores), one-cycle pulse.
- i_miss_r  in  1  puck passed the right edge (left player scores), one-cycle pulse.
- o_state  out  3  current state code (IDLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4).
- o_run  out  1  physics update enable; high only in PLAY.
- o_puck_reset  out  1  one-cycle pulse: re-centre the puck.
- o_serve_dir  out  1  puck launch direction (0 = toward left, 1 = toward right).
- o_score_l, o_score_r  out  $clog2(WIN_SCORE+1)  player scores.
- o_winner_valid  out  1  high in OVER.
- o_winner  out  1  0 = left won, 1 = right won; valid with o_winner_valid.

## Operation
- Start detect:
  - Internal register start_q, reset value 1.
  - start_edge = i_start & ~start_q.
  - A button held high through reset release produces no start.
- IDLE:
  - On start_edge: clear both scores, set serve_dir=1, pulse o_puck_reset, load frame counter with SERVE_FRAMES-1, go to SERVE.
  - Misses are ignored.
- SERVE:
  - On each i_nf: if counter==0, go to PLAY; else decrement.
  - Exactly SERVE_FRAMES i_nf pulses are consumed.
  - Misses and start_edge are ignored.
- PLAY:
  - o_run=1.
  - i_miss_l alone: score_r+1 and serve_dir=0.
  - i_miss_r alone: score_l+1 and serve_dir=1.
  - After a single miss: if the incremented score equals WIN_SCORE, go to OVER with winner = the scorer and load OVER_FRAMES-1; else load POINT_FRAMES-1 and go to POINT.
  - Both misses in the same cycle: no score change, serve_dir unchanged, go to POINT.
  - i_nf has no effect in PLAY.
- POINT:
  - Frame countdown as in SERVE.
  - At expiry: pulse o_puck_reset, load SERVE_FRAMES-1, go to SERVE.
- OVER:
  - Scores and winner are held.
  - start_edge: behaves as start from IDLE (new game); this takes priority over a same-cycle expiry.
  - Countdown expiry: go to IDLE, scores retained for display.
- Arithmetic:
  - Score increments saturate at WIN_SCORE.
  - The frame counter is sized $clog2(max(SERVE_FRAMES, POINT_FRAMES, OVER_FRAMES)) bits, minimum 1, and never wraps below 0.
- Reset values: state IDLE, o_run 0, o_puck_reset 0, o_serve_dir 1, scores 0, o_winner_valid 0, o_winner 0, counter 0, start_q 1.
- Reset asserted mid-game returns immediately, asynchronously, to the reset values.

## Timing
- All outputs are registered.
- An event sampled at edge N is visible on outputs after edge N; single-cycle latency.
- o_puck_reset is high for exactly the first cycle of SERVE.
- o_run rises in the first cycle of PLAY and falls in the cycle state leaves PLAY. The physics therefore sees at most one enabled cycle after a miss pulse.
- Duration of SERVE/POINT/OVER is counted in i_nf pulses, not clock cycles. A pulse in the entry cycle counts only if it arrives after the load, i.e. from the next cycle on.
- Back-to-back misses on consecutive cycles: only the first is scored; the second arrives after PLAY is left and is ignored.

## Structure
- Shared package pong_pkg:
  - state enum pong_state_t (3-bit, codes above).
  - Default localparams for WIN_SCORE and the frame counts.
- One sub-module: frame_countdown.
  - Inputs: load and load value, i_nf.
  - Output: done pulse on the i_nf where count==0.
  - Same clock and reset.
- FSM, score registers and start edge detect live in the top module.

## Test plan
- Reset held with i_start=1, then released: state stays IDLE, no o_puck_reset, scores 0.
- start_edge in IDLE, SERVE_FRAMES=3: one o_puck_reset pulse; state SERVE for exactly 3 i_nf pulses, then PLAY with o_run=1.
- In PLAY, i_miss_r: o_score_l goes 0→1, serve_dir=1, state POINT. After POINT_FRAMES i_nf pulses: o_puck_reset pulse, then SERVE.
- i_miss_l and i_miss_r in the same cycle: scores unchanged, state POINT.
- WIN_SCORE=2, two i_miss_l in separate PLAY phases: o_score_r=2, state OVER, o_winner_valid=1, o_winner=1, o_run=0. After OVER_FRAMES frames: IDLE with scores held.
- start_edge in OVER: scores cleared, SERVE entered. Separately, i_rst_n asserted mid-PLAY: all outputs return to reset values without waiting for a clock edge.
